odu_gen_data: RTL and testbench

//  Synthetic ODU traffic generator: emits 384-bit ODU frame words for up to 16
//  TDM slots, each tagged with a 7-bit channel ID. Used as a test-data source

---
 rtl/odu_gen_data.sv | 94 +++++++++
 tb/tb_odu_gen_data.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/odu_gen_data.sv
// odu_gen_data: synthetic ODU frame-word generator for 16 TDM slots, configured over a 16x16 register bus.
module odu_gen_data #(
  parameter int          ROW_WORDS = 80,
  parameter logic [15:0] VERSION   = 16'h0D01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_n_cs,
  input  logic         cfg_n_we,
  input  logic         cfg_n_oe,
  input  logic [3:0]   cfg_addr,
  input  logic [15:0]  cfg_din,
  output logic [15:0]  cfg_dout,
  output logic [6:0]   chid_out,
  output logic [386:0] data_out
);
  localparam int CW = $clog2(ROW_WORDS);
  logic [15:0]   regs [16];
  logic [3:0]    ptr;
  logic [1:0]    row  [16];
  logic [CW-1:0] col  [16];
  logic [7:0]    mfas [16];
  logic [7:0]    seq  [16];
  logic          wr, rd, tbl_wr, gen_en, slot_en, fs, rs, col_end;
  logic [7:0]    slot_byte;
  logic [15:0]   slot_reg;
  logic [383:0]  word;
  assign wr      = !cfg_n_cs && !cfg_n_we;
  assign rd      = !cfg_n_cs && cfg_n_we && !cfg_n_oe;
  assign tbl_wr  = wr && cfg_addr >= 4'd1 && cfg_addr <= 4'd8;
  assign gen_en  = regs[11][0];
  assign slot_reg  = regs[{1'b0, ptr[3:1]} + 4'd1];
  assign slot_byte = ptr[0] ? slot_reg[15:8] : slot_reg[7:0];
  assign slot_en = slot_byte[7];
  assign rs      = col[ptr] == '0;
  assign fs      = rs && row[ptr] == 2'd0;
  assign col_end = col[ptr] == CW'(ROW_WORDS - 1);
  // Payload bytes count up from the slot's running sequence; frame-start words carry FAS and MFAS.
  always_comb begin
    word = '0;
    for (int j = 0; j < 48; j++) word[383-8*j -: 8] = seq[ptr] + 8'(j);
    if (fs) begin
      word[383 -: 48] = 48'hF6F6F6282828;
      word[335 -: 8]  = mfas[ptr];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) regs[k] <= '0;
      for (int k = 0; k < 16; k++) begin
        row[k]  <= '0;
        col[k]  <= '0;
        mfas[k] <= '0;
        seq[k]  <= '0;
      end
      ptr      <= '0;
      cfg_dout <= '0;
      chid_out <= '0;
      data_out <= '0;
    end else begin
      if (wr && cfg_addr >= 4'd1 && cfg_addr <= 4'd11) regs[cfg_addr] <= cfg_din;
      cfg_dout <= rd ? (cfg_addr == 4'd0 ? VERSION : regs[cfg_addr]) : '0;
      if (!gen_en) begin
        ptr      <= '0;
        chid_out <= '0;
        data_out <= '0;
        for (int k = 0; k < 16; k++) begin
          row[k]  <= '0;
          col[k]  <= '0;
          mfas[k] <= '0;
          seq[k]  <= '0;
        end
      end else begin
        ptr      <= ptr + 4'd1;
        chid_out <= slot_en ? slot_byte[6:0] : '0;
        data_out <= slot_en ? {1'b1, fs, rs, word} : '0;
        if (slot_en) begin
          col[ptr] <= col_end ? '0 : col[ptr] + CW'(1);
          row[ptr] <= col_end ? row[ptr] + 2'd1 : row[ptr];
          mfas[ptr] <= (col_end && row[ptr] == 2'd3) ? mfas[ptr] + 8'd1 : mfas[ptr];
          seq[ptr] <= seq[ptr] + 8'd48;
        end
      end
      // Rewriting a slot-table byte restarts that slot at frame start, overriding any advance.
      for (int k = 0; k < 16; k++)
        if (tbl_wr && (cfg_addr - 4'd1) == 4'(k / 2)) begin
          row[k]  <= '0;
          col[k]  <= '0;
          mfas[k] <= '0;
          seq[k]  <= '0;
        end
    end
  end
endmodule

// File: tb/tb_odu_gen_data.sv
// tb_odu_gen_data: directed and random bus traffic against a per-slot word-count reference model.
module tb_odu_gen_data;
  logic         clk = 0;
  logic         rst = 1;
  logic         cfg_n_cs = 1, cfg_n_we = 1, cfg_n_oe = 1;
  logic [3:0]   cfg_addr = '0;
  logic [15:0]  cfg_din = '0;
  logic [15:0]  cfg_dout;
  logic [6:0]   chid_out;
  logic [386:0] data_out;
  int total = 0, bad = 0;
  logic [15:0]  sh [16];
  int           n [16];
  int           p;
  int           seen [128];
  bit           dir = 0;
  logic [386:0] e_data;
  logic [6:0]   e_chid;
  logic [15:0]  e_dout;

  odu_gen_data dut (
    .clk(clk), .rst(rst), .cfg_n_cs(cfg_n_cs), .cfg_n_we(cfg_n_we), .cfg_n_oe(cfg_n_oe),
    .cfg_addr(cfg_addr), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
    .chid_out(chid_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [386:0] obs, input logic [386:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word number cnt of a slot since its last restart, from the frame arithmetic alone.
  function automatic logic [386:0] mk(input int cnt);
    logic [383:0] w;
    int col, row;
    logic fs, rs;
    col = cnt % 80;
    row = (cnt / 80) % 4;
    rs = (col == 0);
    fs = rs && row == 0;
    for (int j = 0; j < 48; j++) w[383-8*j -: 8] = 8'((48 * cnt + j) % 256);
    if (fs) begin
      w[383 -: 48] = 48'hF6F6F6282828;
      w[335 -: 8]  = 8'((cnt / 320) % 256);
    end
    return {1'b1, fs, rs, w};
  endfunction

  task automatic step(input logic r, cs, we, oe, input logic [3:0] a, input logic [15:0] d);
    logic [7:0] b;
    int c;
    rst = r; cfg_n_cs = cs; cfg_n_we = we; cfg_n_oe = oe; cfg_addr = a; cfg_din = d;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 16; k++) begin sh[k] = '0; n[k] = 0; end
      p = 0; e_data = '0; e_chid = '0; e_dout = '0;
    end else begin
      e_dout = (!cs && we && !oe) ? (a == 0 ? 16'h0D01 : sh[a]) : 16'h0;
      if (!sh[11][0]) begin
        p = 0; e_data = '0; e_chid = '0;
        for (int k = 0; k < 16; k++) n[k] = 0;
      end else begin
        b = (p % 2) ? sh[p / 2 + 1][15:8] : sh[p / 2 + 1][7:0];
        if (b[7]) begin
          e_data = mk(n[p]); e_chid = b[6:0]; n[p]++;
        end else begin
          e_data = '0; e_chid = '0;
        end
        p = (p + 1) % 16;
      end
      if (!cs && !we) begin
        if (a >= 1 && a <= 11) sh[a] = d;
        if (a >= 1 && a <= 8) begin n[2 * (a - 1)] = 0; n[2 * (a - 1) + 1] = 0; end
      end
    end
    #1;
    chk("data", data_out, e_data);
    chk("chid", 387'(chid_out), 387'(e_chid));
    chk("dout", 387'(cfg_dout), 387'(e_dout));
    if (dir && data_out[386] === 1'b1) begin
      c = int'(chid_out);
      if (seen[c] == 0)   chk("first_fs", 387'(data_out[386:328]), 387'({3'b111, 56'hF6F6F6282828_00}));
      if (seen[c] == 1)   chk("second", 387'({data_out[385:384], data_out[383:376]}), 387'({2'b00, 8'h30}));
      if (seen[c] == 80)  chk("row1", 387'(data_out[385:384]), 387'(2'b01));
      if (seen[c] == 320) chk("frame2", 387'({data_out[385:384], data_out[335:328]}), 387'({2'b11, 8'h01}));
      seen[c]++;
    end
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) step(0, 1, 1, 1, 4'd0, 16'h0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    step(0, 0, 0, 1, a, d);
  endtask
  task automatic rd(input logic [3:0] a);
    step(0, 0, 1, 0, a, 16'h0);
  endtask

  initial begin
    logic [3:0]  ra;
    logic [15:0] rdat;
    int sel;
    for (int k = 0; k < 128; k++) seen[k] = 0;
    step(1, 1, 1, 1, 4'd0, 16'h0);
    step(1, 1, 1, 1, 4'd0, 16'h0);
    chk("rst_data", data_out, '0);
    chk("rst_dout", 387'(cfg_dout), '0);
    rd(4'd0);
    chk("version", 387'(cfg_dout), 387'(16'h0D01));
    idle(1);
    chk("idle_rd", 387'(cfg_dout), '0);
    wr(4'd1, 16'h8183);
    wr(4'd3, 16'h0707);
    wr(4'd6, 16'h8082);
    dir = 1;
    wr(4'd11, 16'h0001);
    idle(16 * 330);
    dir = 0;
    rd(4'd11);
    rd(4'd1);
    rd(4'd13);
    wr(4'd11, 16'h0000);
    idle(3);
    chk("disabled", 387'(data_out[386]), '0);
    wr(4'd11, 16'h0001);
    idle(40);
    wr(4'd1, 16'h8183);
    idle(40);
    wr(4'd0, 16'h1234);
    rd(4'd0);
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 9);
      ra = 4'($urandom_range(0, 15));
      rdat = 16'($urandom);
      if (ra == 4'd11) rdat[0] = ($urandom_range(0, 3) != 0);
      if (sel == 0) wr(ra, rdat);
      else if (sel == 1) rd(ra);
      else if (sel == 2 && $urandom_range(0, 60) == 0) step(1, 1, 1, 1, 4'd0, 16'h0);
      else idle(1);
      if (i == 750) wr(4'd11, 16'h0001);
    end
    step(1, 1, 1, 1, 4'd0, 16'h0);
    chk("rst_mid", data_out, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
